// File: rtl/led_pattern_gen_if.sv
// Control and status bundle for led_pattern_gen: run controls in, LED drive and step pulse out.
interface led_pattern_gen_if #(
    parameter int N_LEDS = 6,
    parameter int DIV_W  = 26
);
    logic              en;
    logic [1:0]        mode;
    logic [DIV_W-1:0]  period;
    logic [3:0]        duty;
    logic [N_LEDS-1:0] led;
    logic              step;

    modport master (output en, mode, period, duty, input led, step);
    modport slave  (input en, mode, period, duty, output led, step);
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled step events advance a rotate/bounce/count pattern,
// and a 15-cycle PWM counter gates the registered LED drive for brightness.
module led_pattern_gen #(
    parameter int N_LEDS = 6,
    parameter int DIV_W  = 26
) (
    input  logic             clk,
    input  logic             rst,
    led_pattern_gen_if.slave bus
);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    localparam logic [1:0] MODE_ROL    = 2'b00;
    localparam logic [1:0] MODE_ROR    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;
    localparam logic [3:0] PC_LAST     = 4'd14;

    logic [DIV_W-1:0]  cnt, cnt_next;
    logic [N_LEDS-1:0] pattern, pattern_next;
    logic [1:0]        mode_q, mode_q_next;
    dir_t              dir, dir_next;
    logic [3:0]        pc;
    logic              step_evt;
    logic              pwm_on;
    logic [N_LEDS-1:0] led_q;
    logic              step_q;

    assign bus.led  = led_q;
    assign bus.step = step_q;

    // The >= compare lets a shortened period take effect immediately instead of waiting for a wrap.
    always_comb begin
        step_evt     = bus.en && (cnt >= bus.period);
        pwm_on       = (pc < bus.duty);
        cnt_next     = cnt;
        pattern_next = pattern;
        mode_q_next  = mode_q;
        dir_next     = dir;

        if (bus.en) begin
            cnt_next = step_evt ? '0 : cnt + DIV_W'(1);
        end

        if (step_evt) begin
            if (bus.mode != mode_q) begin
                mode_q_next  = bus.mode;
                dir_next     = DIR_UP;
                pattern_next = (bus.mode == MODE_COUNT) ? '0 : N_LEDS'(1);
            end else begin
                case (mode_q)
                    MODE_ROL: pattern_next = {pattern[N_LEDS-2:0], pattern[N_LEDS-1]};
                    MODE_ROR: pattern_next = {pattern[0], pattern[N_LEDS-1:1]};
                    MODE_BOUNCE: begin
                        if (dir == DIR_UP) begin
                            if (pattern[N_LEDS-1]) begin
                                dir_next     = DIR_DOWN;
                                pattern_next = pattern >> 1;
                            end else begin
                                pattern_next = pattern << 1;
                            end
                        end else begin
                            if (pattern[0]) begin
                                dir_next     = DIR_UP;
                                pattern_next = pattern << 1;
                            end else begin
                                pattern_next = pattern >> 1;
                            end
                        end
                    end
                    default: pattern_next = pattern + N_LEDS'(1);
                endcase
            end
        end
    end

    // The PWM counter free-runs regardless of en so a frozen pattern still dims correctly.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            pc      <= '0;
            pattern <= N_LEDS'(1);
            mode_q  <= MODE_ROL;
            dir     <= DIR_UP;
            led_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            pc      <= (pc == PC_LAST) ? 4'd0 : pc + 4'd1;
            pattern <= pattern_next;
            mode_q  <= mode_q_next;
            dir     <= dir_next;
            led_q   <= pattern & {N_LEDS{pwm_on}};
            step_q  <= step_evt;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized and directed bench for led_pattern_gen, checked against a sweep-index based reference model.
module tb_led_pattern_gen;

    localparam int N    = 6;
    localparam int DW   = 26;
    localparam int MASK = (1 << N) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    // Reference model state: bounce is tracked as a position in the sweep, not a shift direction.
    int m_cnt, m_pc, m_mode_q, m_phase, m_pat;
    int exp_led, exp_step;

    led_pattern_gen_if #(.N_LEDS(N), .DIV_W(DW)) bus ();

    led_pattern_gen #(.N_LEDS(N), .DIV_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int modelPattern();
        int pos;
        if (m_mode_q == 2) begin
            pos = (m_phase < N) ? m_phase : (2 * N - 2 - m_phase);
            return 1 << pos;
        end
        return m_pat;
    endfunction

    task automatic modelReset();
        m_cnt    = 0;
        m_pc     = 0;
        m_mode_q = 0;
        m_pat    = 1;
        m_phase  = 0;
        exp_led  = 0;
        exp_step = 0;
    endtask

    task automatic modelEdge(input int e, input int m, input int p, input int d);
        int cur;
        int fire;
        cur      = modelPattern();
        exp_led  = (m_pc < d) ? cur : 0;
        m_pc     = (m_pc + 1) % 15;
        fire     = (e != 0 && m_cnt >= p) ? 1 : 0;
        exp_step = fire;
        if (e != 0) m_cnt = fire ? 0 : m_cnt + 1;
        if (fire != 0) begin
            if (m != m_mode_q) begin
                m_mode_q = m;
                m_pat    = (m == 3) ? 0 : 1;
                m_phase  = 0;
            end else begin
                case (m_mode_q)
                    0: m_pat = ((cur << 1) | (cur >> (N - 1))) & MASK;
                    1: m_pat = ((cur >> 1) | (cur << (N - 1))) & MASK;
                    2: m_phase = (m_phase + 1) % (2 * N - 2);
                    default: m_pat = (cur + 1) % (1 << N);
                endcase
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare away from the edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                                 input logic [DW-1:0] p, input logic [3:0] d);
        rst        = r;
        bus.en     = e;
        bus.mode   = m;
        bus.period = p;
        bus.duty   = d;
        @(posedge clk);
        if (r) modelReset();
        else   modelEdge(int'(e), int'(m), int'(p), int'(d));
        @(negedge clk);
        checkOutput("led", 32'(bus.led), 32'(exp_led));
        checkOutput("step", 32'(bus.step), 32'(exp_step));
    endtask

    initial begin
        int bounce_seq[13] = '{1, 1, 2, 4, 8, 16, 32, 16, 8, 4, 2, 1, 2};
        logic       r_s;
        logic       e_s;
        logic [1:0] m_s;
        logic [3:0] d_s;
        logic [DW-1:0] p_s;

        modelReset();
        @(negedge clk);

        applyStimulus(1'b1, 1'b1, 2'b10, DW'(0), 4'd15);
        applyStimulus(1'b1, 1'b1, 2'b10, DW'(0), 4'd15);
        checkOutput("rst_led", 32'(bus.led), 32'd0);
        checkOutput("rst_step", 32'(bus.step), 32'd0);

        // Rotate-left at period 3: step every fourth enabled cycle.
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1, 2'b00, DW'(3), 4'd15);

        // Bounce at period 0 from reset: reseed on the first step, then one sweep value per cycle.
        applyStimulus(1'b1, 1'b0, 2'b00, DW'(0), 4'd15);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b0, 1'b1, 2'b10, DW'(0), 4'd15);
            checkOutput("bounce_seq", 32'(bus.led), 32'(bounce_seq[i]));
        end

        // Binary count through a full wrap, then an interrupting switch to rotate-right.
        for (int i = 0; i < 70; i++) applyStimulus(1'b0, 1'b1, 2'b11, DW'(0), 4'd15);
        for (int i = 0; i < 4; i++)  applyStimulus(1'b0, 1'b1, 2'b01, DW'(0), 4'd15);

        // PWM with frozen pattern = 4.
        applyStimulus(1'b1, 1'b0, 2'b00, DW'(0), 4'd15);
        applyStimulus(1'b0, 1'b1, 2'b00, DW'(0), 4'd15);
        applyStimulus(1'b0, 1'b1, 2'b00, DW'(0), 4'd15);
        for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b0, 2'b00, DW'(0), 4'd5);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 2'b00, DW'(0), 4'd0);

        // Period lowered below the running count, then reset mid-period.
        applyStimulus(1'b1, 1'b0, 2'b00, DW'(0), 4'd15);
        for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b1, 2'b00, DW'(100), 4'd15);
        applyStimulus(1'b0, 1'b1, 2'b00, DW'(10), 4'd15);
        checkOutput("period_drop", 32'(bus.step), 32'd1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 2'b00, DW'(10), 4'd15);
        applyStimulus(1'b1, 1'b1, 2'b00, DW'(10), 4'd15);
        checkOutput("midrst_led", 32'(bus.led), 32'd0);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, 1'b1, 2'b00, DW'(10), 4'd15);
            checkOutput("post_rst_step", 32'(bus.step), (i == 10) ? 32'd1 : 32'd0);
        end

        // Randomized traffic.
        m_s = 2'b00;
        d_s = 4'd15;
        for (int i = 0; i < 800; i++) begin
            r_s = ($urandom_range(0, 63) == 0);
            e_s = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) m_s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)  d_s = 4'($urandom_range(0, 15));
            p_s = DW'($urandom_range(0, 5));
            applyStimulus(r_s, e_s, m_s, p_s, d_s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL provide parameter N_LEDS, default 6, number of LED outputs; legal range 2..32.
REQ-002 SHALL provide parameter DIV_W, default 26, width of the step-period prescaler.
REQ-003 clk  input  1  system clock; all logic on rising edge; one clock domain only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  run enable; 0 freezes prescaler and pattern.
REQ-006 mode  input  2  pattern mode: 00 rotate-left, 01 rotate-right, 10 bounce, 11 binary count.
REQ-007 period  input  DIV_W  step period minus one, in clk cycles.
REQ-008 duty  input  4  brightness; 0 = off, 15 = fully on.
REQ-009 led  output  N_LEDS  registered LED drive, 1 = lit.
REQ-010 step  output  1  registered one-cycle pulse on every pattern advance.

Function
REQ-011 SHALL hold prescaler count cnt (DIV_W bits); with en=1, if cnt >= period then cnt <= 0 and a step event fires, else cnt <= cnt+1.
REQ-012 period=0 SHALL fire a step event every enabled cycle; step period = period+1 cycles.
REQ-013 A period lowered below the current cnt SHALL fire a step event on the next enabled edge (the >= compare); it SHALL NOT wait for cnt to wrap.
REQ-014 en=0 SHALL hold cnt, pattern, direction and mode_q; step SHALL be 0; the PWM counter keeps running.
REQ-015 On a step event with mode == mode_q, pattern SHALL advance per mode_q:
 - rotate-left: {p[N-2:0], p[N-1]};
 - rotate-right: {p[0], p[N-1:1]};
 - bounce: one-hot shift in dir; at bit N-1 going up, dir <= down and shift right; at bit 0 going down, dir <= up and shift left; end bits shown once per sweep (N=6: 1,2,4,8,16,32,16,8,4,2,1,2...);
 - count: p+1 modulo 2^N_LEDS; all-ones wraps to 0.
REQ-016 On a step event with mode != mode_q, mode_q <= mode, dir <= up, and pattern SHALL load the seed (1 for modes 00/01/10, 0 for 11) instead of advancing.
REQ-017 mode changes between step events SHALL have no effect until the next step event.
REQ-018 In bounce mode a non-one-hot pattern is unreachable; no recovery logic required.
REQ-019 step SHALL be 1 in the cycle after the edge that updated pattern, else 0.
REQ-020 PWM counter pc (4 bits) SHALL count 0..14 and wrap to 0 (period 15 cycles); pwm_on = (pc < duty).
REQ-021 led SHALL be registered as pattern AND {N_LEDS{pwm_on}}, lagging pattern by one cycle; duty=15 gives led = pattern constantly; duty=0 gives led = 0 constantly.
REQ-022 duty changes SHALL take effect on the next clock edge, with no pattern disturbance.

Reset
REQ-023 rst=1 at a rising edge SHALL set cnt=0, pc=0, pattern=1, mode_q=00, dir=up, led=0, step=0; rst overrides en and all other inputs.
REQ-024 Reset mid-step-period SHALL discard partial count; the first step event after release occurs period+1 enabled cycles later.
REQ-025 After release, mode != 00 SHALL be reseeded on the first step event per REQ-016.

Verification
REQ-026 N_LEDS=6, period=3, mode=00, duty=15, en=1 after reset -> step every 4 cycles; pattern 1,2,4,8,16,32,1; led tracks one cycle later.
REQ-027 mode=10, period=0 -> led sequence 1,2,4,8,16,32,16,8,4,2,1,2, one value per cycle.
REQ-028 mode=11, N_LEDS=3, period=0 -> first step seeds 0, then 1..7,0 wrap; switching to 01 mid-count -> next step loads 1, following step gives 4.
REQ-029 duty=5, pattern=4, en=0 -> led=4 for 5 cycles then 0 for 10, repeating every 15; duty=0 -> led=0; step stays 0 with en=0.
REQ-030 period=100, cnt reaches 50, period rewritten to 10 -> step on next edge; rst asserted at cnt=7 -> all outputs 0, pattern=1, next step 11 cycles after release.
